// File: rtl/sevenseg_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver_pkg
//   Shared constants for the safe-lock front-panel seven-segment driver:
//   special display codes, the active-high glyph table and the site-wide
//   glyph mask applied to digit code 4.
//   Segment vectors are ordered {a,b,c,d,e,f,g} = [6:0] and are active-high
//   here; panel polarity is applied only at the output registers.
// ---------------------------------------------------------------------------
package sevenseg_scan_driver_pkg;

    // Site-wide mask XORed into the glyph for code 4. Zero keeps the
    // standard four-segment '4'; panels with a serifed 4 set bit a here.
    localparam logic [6:0] GLYPH_MASK = 7'b0000000;

    // Codes with a non-numeric meaning.
    localparam logic [3:0] CODE_E     = 4'hC;
    localparam logic [3:0] CODE_R     = 4'hD;
    localparam logic [3:0] CODE_BLANK = 4'hE;

    // Active-high "all segments dark" pattern.
    localparam logic [6:0] SEG_OFF    = 7'b0000000;

    // Active-high glyphs, {a,b,c,d,e,f,g}.
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_E = 7'b1001111; // a,d,e,f,g
    localparam logic [6:0] GLYPH_R = 7'b0000101; // e,g

    // Converts an active-high pattern to panel polarity.
    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern,
                                                input logic       active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// ---------------------------------------------------------------------------
// sevenseg_glyph_decode
//   Purely combinational code-to-glyph decoder. Output is active-high.
//   Ports:
//     code   in  4  display code: 0-9 digits, C='E', D='r', A/B/E/F blank
//     glyph  out 7  segments {a,b,c,d,e,f,g}, active-high
// ---------------------------------------------------------------------------
module sevenseg_glyph_decode
    import sevenseg_scan_driver_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (code)
            4'h0:   glyph = GLYPH_0;
            4'h1:   glyph = GLYPH_1;
            4'h2:   glyph = GLYPH_2;
            4'h3:   glyph = GLYPH_3;
            4'h4:   glyph = GLYPH_4 ^ GLYPH_MASK;
            4'h5:   glyph = GLYPH_5;
            4'h6:   glyph = GLYPH_6;
            4'h7:   glyph = GLYPH_7;
            4'h8:   glyph = GLYPH_8;
            4'h9:   glyph = GLYPH_9;
            CODE_E: glyph = GLYPH_E;
            CODE_R: glyph = GLYPH_R;
            // CODE_BLANK and the unused codes A, B, F all render dark.
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed N-digit seven-segment driver. One digit is lit per slot
//   of REFRESH_DIV cycles; the first BLANK_CYCLES of every slot keep all
//   anodes off so the previous digit's segments never ghost onto the next.
//   Display words are written into a shadow buffer and committed to the
//   active buffer only at the frame boundary (wrap into digit 0), so a frame
//   is always drawn from one consistent word.
//
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     enable       0: outputs dark, divider/digit/blink state frozen
//     load         1-cycle strobe capturing codes/blink_en/dp into shadow
//     codes        4 bits per digit, digit 0 in [3:0] (rightmost)
//     blink_en     per-digit blink enable
//     dp           per-digit decimal point
//     seg          segments {a..g}, polarity per ACTIVE_LOW
//     dp_out       decimal point, polarity per ACTIVE_LOW
//     an           digit enables, polarity per ACTIVE_LOW
//     frame_tick   high during the cycle that wraps into digit 0
//     pending      shadow holds a word not yet committed
// ---------------------------------------------------------------------------
module sevenseg_scan_driver
    import sevenseg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    pending
);

    // ---------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------
    if (NUM_DIGITS < 1) begin : g_bad_digits
        $error("sevenseg_scan_driver: NUM_DIGITS must be >= 1");
    end
    if (BLANK_CYCLES < 0) begin : g_bad_blank
        $error("sevenseg_scan_driver: BLANK_CYCLES must be >= 0");
    end
    if (REFRESH_DIV < BLANK_CYCLES + 2) begin : g_bad_div
        $error("sevenseg_scan_driver: REFRESH_DIV must be >= BLANK_CYCLES+2");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("sevenseg_scan_driver: BLINK_FRAMES must be >= 1");
    end
    if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_pol
        $error("sevenseg_scan_driver: ACTIVE_LOW must be 0 or 1");
    end

    // ---------------------------------------------------------------
    // Derived constants
    // ---------------------------------------------------------------
    localparam int CODE_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int DIG_W  = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
    localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DIV_BLANK  = CNT_W'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);

    localparam logic             POL        = (ACTIVE_LOW != 0);
    localparam logic [6:0]       SEG_IDLE   = seg_polarity(SEG_OFF, POL);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{POL}};
    localparam logic [CODE_W-1:0] CODES_RST = {NUM_DIGITS{CODE_BLANK}};

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [CNT_W-1:0]      div_cnt_q,     div_cnt_d;
    logic [DIG_W-1:0]      dig_idx_q,     dig_idx_d;
    logic [BLK_W-1:0]      blink_cnt_q,   blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;

    logic [CODE_W-1:0]     sh_codes_q,    sh_codes_d;
    logic [NUM_DIGITS-1:0] sh_blink_q,    sh_blink_d;
    logic [NUM_DIGITS-1:0] sh_dp_q,       sh_dp_d;
    logic                  pending_q,     pending_d;

    logic [CODE_W-1:0]     act_codes_q,   act_codes_d;
    logic [NUM_DIGITS-1:0] act_blink_q,   act_blink_d;
    logic [NUM_DIGITS-1:0] act_dp_q,      act_dp_d;

    logic [6:0]            seg_q,         seg_d;
    logic                  dp_out_q,      dp_out_d;
    logic [NUM_DIGITS-1:0] an_q,          an_d;

    // ---------------------------------------------------------------
    // Scan position decode
    // ---------------------------------------------------------------
    logic slot_end;
    logic boundary;

    // Counters only move while enabled, so a disabled driver never
    // reaches a boundary and never commits.
    assign slot_end = enable && (div_cnt_q == DIV_LAST);
    assign boundary = slot_end && (dig_idx_q == DIG_LAST);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            dig_idx_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sh_codes_q    <= CODES_RST;
            sh_blink_q    <= '0;
            sh_dp_q       <= '0;
            pending_q     <= 1'b0;
            act_codes_q   <= CODES_RST;
            act_blink_q   <= '0;
            act_dp_q      <= '0;
            seg_q         <= SEG_IDLE;
            dp_out_q      <= POL;
            an_q          <= AN_IDLE;
        end else begin
            div_cnt_q     <= div_cnt_d;
            dig_idx_q     <= dig_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sh_codes_q    <= sh_codes_d;
            sh_blink_q    <= sh_blink_d;
            sh_dp_q       <= sh_dp_d;
            pending_q     <= pending_d;
            act_codes_q   <= act_codes_d;
            act_blink_q   <= act_blink_d;
            act_dp_q      <= act_dp_d;
            seg_q         <= seg_d;
            dp_out_q      <= dp_out_d;
            an_q          <= an_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state: divider, digit index and blink counters
    // ---------------------------------------------------------------
    always_comb begin
        div_cnt_d     = div_cnt_q;
        dig_idx_d     = dig_idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (enable) begin
            if (slot_end) begin
                div_cnt_d = '0;
                dig_idx_d = (dig_idx_q == DIG_LAST) ? '0
                                                    : dig_idx_q + DIG_W'(1);
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end

        // Blink cadence is measured in whole frames.
        if (boundary) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Next-state: shadow / active double buffer
    // ---------------------------------------------------------------
    always_comb begin
        sh_codes_d  = sh_codes_q;
        sh_blink_d  = sh_blink_q;
        sh_dp_d     = sh_dp_q;
        pending_d   = pending_q;
        act_codes_d = act_codes_q;
        act_blink_d = act_blink_q;
        act_dp_d    = act_dp_q;

        if (boundary) begin
            if (load) begin
                // A load landing on the commit cycle is newer than anything
                // in the shadow, so it bypasses straight to active. Shadow is
                // kept in step so it never holds stale data.
                act_codes_d = codes;
                act_blink_d = blink_en;
                act_dp_d    = dp;
                sh_codes_d  = codes;
                sh_blink_d  = blink_en;
                sh_dp_d     = dp;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                act_codes_d = sh_codes_q;
                act_blink_d = sh_blink_q;
                act_dp_d    = sh_dp_q;
                pending_d   = 1'b0;
            end
        end else if (load) begin
            // Repeated loads simply overwrite: the last one wins.
            sh_codes_d = codes;
            sh_blink_d = blink_en;
            sh_dp_d    = dp;
            pending_d  = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Digit mux and glyph decode
    // ---------------------------------------------------------------
    logic [3:0]            code_sel;
    logic                  blink_sel;
    logic                  dp_sel;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [6:0]            glyph;

    // Compare-based select keeps non-power-of-two digit counts safe.
    always_comb begin
        code_sel  = CODE_BLANK;
        blink_sel = 1'b0;
        dp_sel    = 1'b0;
        an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_idx_q == DIG_W'(i)) begin
                code_sel     = act_codes_q[4*i +: 4];
                blink_sel    = act_blink_q[i];
                dp_sel       = act_dp_q[i];
                an_onehot[i] = 1'b1;
            end
        end
    end

    sevenseg_glyph_decode u_glyph_decode (
        .code  (code_sel),
        .glyph (glyph)
    );

    // ---------------------------------------------------------------
    // Output next-state (registered, one cycle behind the scan position)
    // ---------------------------------------------------------------
    logic                  lit;
    logic                  dark_digit;
    logic [6:0]            seg_on;
    logic                  dp_on;
    logic [NUM_DIGITS-1:0] an_on;

    always_comb begin
        // Anodes drive only after the ghost guard of the slot.
        lit        = enable && (div_cnt_q >= DIV_BLANK);
        // A blinking digit goes dark but keeps its anode, so the scan duty
        // (and thus perceived brightness of the other digits) is unchanged.
        dark_digit = blink_sel && blink_phase_q;

        seg_on     = (lit && !dark_digit) ? glyph : SEG_OFF;
        dp_on      = lit && !dark_digit && dp_sel;
        an_on      = lit ? an_onehot : '0;

        seg_d      = seg_polarity(seg_on, POL);
        dp_out_d   = dp_on ^ POL;
        an_d       = an_on ^ AN_IDLE;
    end

    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_tick = boundary && !rst;

endmodule
